// File: rtl/match_window_counter_pkg.sv
// match_pkg: shared types and helpers for match_window_counter.
//   out_state_t : state of the single-entry output register
//   sat_inc     : increment that sticks at 2^width-1
package match_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Increment value by one, holding at 2^width-1 once it gets there.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] limit;
    limit = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/match_window_counter_window_timer.sv
// window_timer: free-running mod-WINDOW cycle counter.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset, forces wcnt to 0
//   wcnt  out  current window cycle, 0..WINDOW-1
//   last  out  high in the final cycle of the window (wcnt == WINDOW-1)
module window_timer
  import match_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WCNT_W-1:0] wcnt,
  output logic              last
);

  assign last = (wcnt == WCNT_W'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (last) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + WCNT_W'(1);
    end
  end

endmodule

// File: rtl/match_window_counter.sv
// match_window_counter: counts match pulses over fixed windows of WINDOW
// cycles and hands each window's count to a reader through a single-entry
// valid/ready register. A window result that arrives while the previous one
// is still unconsumed is discarded and flagged on dropped.
//
// Optional feature: define MATCH_WINDOW_ALARM_EN to add the THRESH parameter
// and the registered alarm output (set when a loaded result >= THRESH).
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   match_in   in   match pulse, sampled every cycle
//   cnt_out    out  count of the last completed window
//   cnt_valid  out  cnt_out holds an unconsumed result
//   cnt_ready  in   reader accepts cnt_out when cnt_valid && cnt_ready
//   dropped    out  one-cycle pulse: a completed window result was discarded
//   alarm      out  (MATCH_WINDOW_ALARM_EN only) last loaded result >= THRESH
//
// Output register states:
//   state     | meaning
//   OUT_EMPTY | no unconsumed result; next window close loads cnt_out
//   OUT_FULL  | cnt_out valid and held until handshake
module match_window_counter
  import match_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
`ifdef MATCH_WINDOW_ALARM_EN
  ,
  parameter int THRESH = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
`ifdef MATCH_WINDOW_ALARM_EN
  output logic             alarm,
`endif
  output logic             dropped
);

  localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [WCNT_W-1:0] wcnt;
  logic              last;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_cur;
  logic [CNT_W-1:0]  acc_next;
  logic              load_en;
  out_state_t        state;

  window_timer #(
    .WINDOW (WINDOW),
    .WCNT_W (WCNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .wcnt (wcnt),
    .last (last)
  );

  // acc still holds the previous window's total during cycle 0; treating it
  // as zero there restarts the count without a separate clear on close.
  assign acc_cur  = (wcnt == '0) ? '0 : acc;
  assign acc_next = match_in ? CNT_W'(sat_inc(32'(acc_cur), CNT_W)) : acc_cur;

  // A close loads cnt_out unless an unconsumed result is still sitting there.
  assign load_en  = last && ((state == OUT_EMPTY) || cnt_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      state     <= OUT_EMPTY;
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      acc     <= acc_next;
      dropped <= 1'b0;
      case (state)
        OUT_EMPTY: begin
          if (load_en) begin
            cnt_out   <= acc_next;
            cnt_valid <= 1'b1;
            state     <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (last) begin
            // Simultaneous close and handshake swaps in the new result.
            if (load_en) begin
              cnt_out <= acc_next;
            end else begin
              dropped <= 1'b1;
            end
          end else if (cnt_ready) begin
            cnt_valid <= 1'b0;
            state     <= OUT_EMPTY;
          end
        end
        default: begin
          cnt_valid <= 1'b0;
          state     <= OUT_EMPTY;
        end
      endcase
    end
  end

`ifdef MATCH_WINDOW_ALARM_EN
  // Tracks the most recently loaded result only; handshakes leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm <= 1'b0;
    end else if (load_en) begin
      alarm <= (32'(acc_next) >= 32'(THRESH));
    end
  end
`endif

endmodule
